// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer controllers: side select
// and Gray/binary conversion helpers.
package fifo_pkg;

  typedef enum logic {
    PTR_WR = 1'b0,
    PTR_RD = 1'b1
  } ptr_mode_e;

  // Widest pointer supported (ADDR_W up to 8, plus the wrap bit).
  localparam int unsigned PTR_MAX_W = 9;

  // Both conversions are width-agnostic when the operand is zero-extended:
  // callers cast in at PTR_MAX_W and truncate the result to their width.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = g;
    for (int unsigned i = 1; i < PTR_MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-stage flip-flop synchroniser for a Gray pointer crossing in from
// the other clock domain; rst clears every stage.
module ptr_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clck,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stg;

  always_ff @(posedge clck) begin
    if (rst) begin
      stg <= '0;
    end else begin
      stg <= {stg[STAGES-2:0], d};
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Async FIFO pointer controller for one side (MODE 0 = write/full,
// MODE 1 = read/empty). Optional almost flag under FIFO_PTR_ALMOST_EN.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MODE        = 0
`ifdef FIFO_PTR_ALMOST_EN
  , parameter int unsigned ALMOST_TH = 1
`endif
) (
  input  logic            clck,
  input  logic            rst,
  input  logic            inc,
  input  logic [ADDR_W:0] rmt_gray,
  output logic [ADDR_W:0] ptr_gray,
  output logic [ADDR_W-1:0] addr,
  output logic            flag,
  output logic [ADDR_W:0] level
`ifdef FIFO_PTR_ALMOST_EN
  , output logic          almost
`endif
);

  localparam int unsigned PW       = ADDR_W + 1;
  localparam ptr_mode_e   SIDE     = (MODE == 0) ? PTR_WR : PTR_RD;
  localparam logic        FLAG_RST = (SIDE == PTR_RD);

  logic [ADDR_W:0] bin_q;
  logic [ADDR_W:0] bin_nx;
  logic [ADDR_W:0] gray_nx;
  logic [ADDR_W:0] rmt_sync;
  logic [ADDR_W:0] rmt_bin;
  logic [ADDR_W:0] level_nx;
  logic            flag_nx;

  ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clck (clck),
    .rst  (rst),
    .d    (rmt_gray),
    .q    (rmt_sync)
  );

  // Flag and level are derived from the next-state pointer so they are
  // registered in the same cycle as ptr_gray/addr.
  always_comb begin
    bin_nx   = bin_q + {{ADDR_W{1'b0}}, inc & ~flag};
    gray_nx  = PW'(bin2gray(PTR_MAX_W'(bin_nx)));
    rmt_bin  = PW'(gray2bin(PTR_MAX_W'(rmt_sync)));
    flag_nx  = 1'b0;
    level_nx = '0;
    if (SIDE == PTR_WR) begin
      flag_nx  = (gray_nx == {~rmt_sync[ADDR_W -: 2], rmt_sync[ADDR_W-2:0]});
      level_nx = bin_nx - rmt_bin;
    end else begin
      flag_nx  = (gray_nx == rmt_sync);
      level_nx = rmt_bin - bin_nx;
    end
  end

  always_ff @(posedge clck) begin
    if (rst) begin
      bin_q    <= '0;
      ptr_gray <= '0;
      addr     <= '0;
      level    <= '0;
      flag     <= FLAG_RST;
    end else begin
      bin_q    <= bin_nx;
      ptr_gray <= gray_nx;
      addr     <= bin_nx[ADDR_W-1:0];
      level    <= level_nx;
      flag     <= flag_nx;
    end
  end

`ifdef FIFO_PTR_ALMOST_EN
  localparam logic [ADDR_W:0] ALMOST_HI = PW'((1 << ADDR_W) - ALMOST_TH);
  localparam logic [ADDR_W:0] ALMOST_LO = PW'(ALMOST_TH);

  always_ff @(posedge clck) begin
    if (rst) begin
      almost <= FLAG_RST;
    end else if (SIDE == PTR_WR) begin
      almost <= (level_nx >= ALMOST_HI);
    end else begin
      almost <= (level_nx <= ALMOST_LO);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl: one write-side and one read-side
// instance, ADDR_W=3, SYNC_STAGES=2.
module tb_fifo_ptr_ctrl;

  logic       clck = 1'b0;
  logic       rst;
  logic       wr_inc, rd_inc;
  logic [3:0] wr_rmt, rd_rmt;
  logic [3:0] wr_ptr, rd_ptr;
  logic [2:0] wr_addr, rd_addr;
  logic       wr_flag, rd_flag;
  logic [3:0] wr_level, rd_level;
`ifdef FIFO_PTR_ALMOST_EN
  logic       wr_almost, rd_almost;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clck = ~clck;

  fifo_ptr_ctrl #(
    .ADDR_W      (3),
    .SYNC_STAGES (2),
    .MODE        (0)
  ) u_wr (
    .clck     (clck),
    .rst      (rst),
    .inc      (wr_inc),
    .rmt_gray (wr_rmt),
    .ptr_gray (wr_ptr),
    .addr     (wr_addr),
    .flag     (wr_flag),
    .level    (wr_level)
`ifdef FIFO_PTR_ALMOST_EN
    , .almost (wr_almost)
`endif
  );

  fifo_ptr_ctrl #(
    .ADDR_W      (3),
    .SYNC_STAGES (2),
    .MODE        (1)
  ) u_rd (
    .clck     (clck),
    .rst      (rst),
    .inc      (rd_inc),
    .rmt_gray (rd_rmt),
    .ptr_gray (rd_ptr),
    .addr     (rd_addr),
    .flag     (rd_flag),
    .level    (rd_level)
`ifdef FIFO_PTR_ALMOST_EN
    , .almost (rd_almost)
`endif
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clck);
    #1;
  endtask

  function automatic logic [3:0] g4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [3:0] wbin;
  logic [3:0] prev;
  int unsigned n;

  initial begin
    rst = 1'b1; wr_inc = 1'b0; rd_inc = 1'b0; wr_rmt = '0; rd_rmt = '0;
    tick();
    check("rst_wr_ptr",   wr_ptr,   0);
    check("rst_wr_addr",  wr_addr,  0);
    check("rst_wr_level", wr_level, 0);
    check("rst_wr_flag",  wr_flag,  0);
    check("rst_rd_flag",  rd_flag,  1);
    check("rst_rd_level", rd_level, 0);
`ifdef FIFO_PTR_ALMOST_EN
    check("rst_wr_almost", wr_almost, 0);
    check("rst_rd_almost", rd_almost, 1);
`endif
    rst = 1'b0;

    // Read side: remote write pointer jumps to 3, visible 3 edges later.
    rd_rmt = 4'd2;
    tick();
    check("rd_lat1_flag", rd_flag, 1);
    tick();
    check("rd_lat2_flag", rd_flag, 1);
    check("rd_lat2_level", rd_level, 0);
    tick();
    check("rd_lat3_flag", rd_flag, 0);
    check("rd_lat3_level", rd_level, 3);
    rd_inc = 1'b1;
    for (int p = 1; p <= 4; p++) begin
      tick();
      n = (p <= 3) ? 3 - p : 0;
      check("rd_pop_level", rd_level, n);
      check("rd_pop_flag",  rd_flag, (n == 0) ? 1 : 0);
      check("rd_pop_ptr",   rd_ptr, g4((p <= 3) ? p[3:0] : 4'd3));
`ifdef FIFO_PTR_ALMOST_EN
      check("rd_pop_almost", rd_almost, (n <= 1) ? 1 : 0);
`endif
    end
    rd_inc = 1'b0;

    // Write side fills against a remote pointer held at 0.
    wr_inc = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n = (k <= 8) ? k : 8;
      check("wr_fill_ptr",   wr_ptr, g4(n[3:0]));
      check("wr_fill_level", wr_level, n);
      check("wr_fill_flag",  wr_flag, (n == 8) ? 1 : 0);
`ifdef FIFO_PTR_ALMOST_EN
      check("wr_fill_almost", wr_almost, (n >= 7) ? 1 : 0);
`endif
    end
    wr_inc = 1'b0;
    check("wr_full_addr", wr_addr, 0);
    check("wr_full_ptr12", wr_ptr, 12);

    // Remote catches up: full clears exactly three edges later.
    wbin = 4'd8;
    wr_rmt = g4(wbin);
    tick();
    tick();
    check("wr_unfull_lat2", wr_flag, 1);
    tick();
    check("wr_unfull_flag", wr_flag, 0);
    check("wr_unfull_level", wr_level, 0);

    // Push/pop across the wrap with the remote tracking each push.
    prev = wr_ptr;
    for (int s = 0; s < 20; s++) begin
      wr_inc = 1'b1;
      tick();
      wr_inc = 1'b0;
      wbin = wbin + 4'd1;
      check("wrap_ptr",   wr_ptr, g4(wbin));
      check("wrap_addr",  wr_addr, wbin[2:0]);
      check("wrap_onebit", $countones(wr_ptr ^ prev), 1);
      check("wrap_level", wr_level, 1);
      if (wbin == 4'd0) begin
        check("wrap_prev8", prev, 8);
        check("wrap_zero", wr_ptr, 0);
      end
      prev = wr_ptr;
      wr_rmt = g4(wbin);
      tick();
      tick();
      tick();
      check("wrap_drain_level", wr_level, 0);
      check("wrap_drain_flag",  wr_flag, 0);
    end

    // Reset with a push pending at pointer 5.
    rst = 1'b1; wr_rmt = '0;
    tick();
    rst = 1'b0;
    wr_inc = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("pre_rst_ptr",   wr_ptr, 7);
    check("pre_rst_level", wr_level, 5);
    rst = 1'b1;
    tick();
    check("midrst_ptr",   wr_ptr, 0);
    check("midrst_addr",  wr_addr, 0);
    check("midrst_level", wr_level, 0);
    check("midrst_flag",  wr_flag, 0);
    check("midrst_rd_flag", rd_flag, 1);
    rst = 1'b0;
    wr_inc = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
